ascii_rom_arbiter: RTL and testbench

Shares the single synchronous `ascii_rom` (11-bit address, 8-bit glyph row) between several text-rendering clients: title, score, and game-over overlays. It accepts one glyph-row read per cycle over a valid/ready handshake and arbitrates among requesters in round-robin order. Each read is returned with fixed latency, tagged one-hot to the requester that issued it. The block sits between the text overlay generators and the ROM instance in the video pipeline.

---
 rtl/ascii_rom_arbiter.sv | 108 ++++++++++
 tb/tb_ascii_rom_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ascii_rom_arbiter.sv
// ascii_rom_arbiter: shares one synchronous glyph ROM between NUM_REQ text
// overlay clients. One valid/ready grant per cycle. Each response returns
// exactly two cycles after its grant, tagged one-hot to the requester.
// Optional build macro: ASCII_ARB_FIXED_PRIO_EN selects fixed priority, where
// the lowest index wins and no round-robin pointer is built. Without the macro
// the arbiter uses round-robin order.
module ascii_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [ADDR_W-1:0]  win_addr;
  logic [NUM_REQ-1:0] tag1;
  logic [NUM_REQ-1:0] tag2;

`ifdef ASCII_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top down so the lowest valid index ends up winning.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_idx   = IDX_W'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last;

  // Round-robin search starting one past the most recent winner.
  always_comb begin : rr_search
    int unsigned cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last) + k) % NUM_REQ;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_idx   = cand[IDX_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Pointer moves only on a handshake. At reset requester 0 gets first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDX_W'(NUM_REQ - 1);
    end else if (win_found) begin
      last <= win_idx;
    end
  end
`endif

  // Decode the winner to a one-hot ready. Ready is zero when nothing is valid.
  always_comb begin
    req_ready = '0;
    if (win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Select the winning requester's address.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ROM address register and two-stage tag pipeline that matches the ROM latency.
  // req_ready is already zero on idle cycles, so an idle cycle injects a bubble tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      tag1     <= '0;
      tag2     <= '0;
    end else begin
      if (win_found) begin
        rom_addr <= win_addr;
      end
      tag1 <= req_ready;
      tag2 <= tag1;
    end
  end

  assign rsp_valid = tag2;
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_ascii_rom_arbiter.sv
// Self-checking bench for ascii_rom_arbiter with a behavioural synchronous ROM.
// A scoreboard queue holds the expected response (tag, address, due cycle)
// for every grant the bench expects.
module tb_ascii_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [43:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [10:0] exp_rom;

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [10:0] addr;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic [10:0] base;
  } vec_t;
  vec_t tbl [0:16];

  ascii_rom_arbiter #(
    .NUM_REQ(4),
    .ADDR_W (11),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[4:0]} ^ 8'h5A;
  endfunction

  // Synchronous ROM model: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic logic [43:0] addrs(input logic [10:0] base);
    logic [43:0] a;
    for (int i = 0; i < 4; i++) a[i*11 +: 11] = base + 11'(i);
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: drive, check ready/rom_addr mid-cycle, push expectation.
  task automatic drive(input logic [3:0] v, input logic [10:0] base,
                       input logic [3:0] exp, input string name);
    logic [10:0] ga;
    ga = '0;
    req_valid = v;
    req_addr  = addrs(base);
    @(negedge clk);
    chk({name, "_ready"}, 32'(req_ready), 32'(exp));
    chk({name, "_rom_addr"}, 32'(rom_addr), 32'(exp_rom));
    if (exp != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (exp[i]) ga = base + 11'(i);
      q.push_back('{cyc + 2, exp, ga});
      exp_rom = ga;
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every cycle either the due entry or silence.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en && rst_n) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.tag));
        chk("rsp_data", 32'(rsp_data), 32'(rom_fn(e.addr)));
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    exp_rom   = '0;

    tbl[0]  = '{4'b1111, 4'b0001, 11'h100};
    tbl[1]  = '{4'b1111, 4'b0010, 11'h100};
    tbl[2]  = '{4'b1111, 4'b0100, 11'h100};
    tbl[3]  = '{4'b1111, 4'b1000, 11'h100};
    tbl[4]  = '{4'b1111, 4'b0001, 11'h100};
    tbl[5]  = '{4'b1111, 4'b0010, 11'h100};
    tbl[6]  = '{4'b1111, 4'b0100, 11'h100};
    tbl[7]  = '{4'b1111, 4'b1000, 11'h100};
    tbl[8]  = '{4'b1010, 4'b0010, 11'h200};
    tbl[9]  = '{4'b1010, 4'b1000, 11'h210};
    tbl[10] = '{4'b1010, 4'b0010, 11'h220};
    tbl[11] = '{4'b0100, 4'b0100, 11'h230};
    tbl[12] = '{4'b0100, 4'b0100, 11'h240};
    tbl[13] = '{4'b0011, 4'b0001, 11'h250};
    tbl[14] = '{4'b0000, 4'b0000, 11'h260};
    tbl[15] = '{4'b1001, 4'b1000, 11'h270};
    tbl[16] = '{4'b1001, 4'b0001, 11'h280};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    drive(4'b0000, 11'h000, 4'b0000, "idle0");
    drive(4'b0001, 11'h305, 4'b0001, "t1");
    drive(4'b0000, 11'h000, 4'b0000, "t1_gap");
    drive(4'b0000, 11'h000, 4'b0000, "t1_gap");

`ifndef ASCII_ARB_FIXED_PRIO_EN
    // Move the pointer to 3 so the all-valid run starts at requester 0.
    drive(4'b1000, 11'h0F0, 4'b1000, "pre");
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].valid, tbl[k].base, tbl[k].exp_ready, $sformatf("tbl%0d", k));
    end

    // Reset asserted after a second grant is shown: neither response may appear.
    drive(4'b0011, 11'h400, 4'b0010, "mr_a");
    req_valid = 4'b0011;
    @(negedge clk);
    chk("mr_b_ready", 32'(req_ready), 32'b0001);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_rom = '0;
    #1;
    chk("mr_rom_addr", 32'(rom_addr), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("mr_rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("mr_rom_addr2", 32'(rom_addr), 32'd0);
    #2;
    rst_n = 1'b1;
    drive(4'b0110, 11'h500, 4'b0010, "post_rst");

    // Idle gaps: two isolated grants four cycles apart.
    drive(4'b0100, 11'h600, 4'b0100, "gap_a");
    repeat (3) drive(4'b0000, 11'h000, 4'b0000, "gap_idle");
    drive(4'b0001, 11'h610, 4'b0001, "gap_b");
    repeat (2) drive(4'b0000, 11'h000, 4'b0000, "gap_idle2");

    // A single requester is granted every cycle.
    repeat (3) drive(4'b0010, 11'h620, 4'b0010, "single");
`else
    repeat (4) drive(4'b1111, 11'h100, 4'b0001, "fixed");
    drive(4'b0110, 11'h500, 4'b0010, "fixed_b");
`endif

    repeat (4) drive(4'b0000, 11'h000, 4'b0000, "drain");
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
